// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data memory with fixed wait states,
// BEQ resolution, and the MEM/WB slot registers. Define MISALIGN_TRAP_EN to add outMisalign.
module mem_access_stage #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [31:0] pcAdder,
  input  logic        zeroflag,
  input  logic [31:0] Alu_result,
  input  logic [31:0] DataWrite,
  input  logic [4:0]  muxRegFileD,
  input  logic        branch,
  input  logic        memtoWrite,
  input  logic        memtoRead,
  input  logic        regWrite,
  input  logic        memtoReg,
  output logic        stall,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic        outValid,
  output logic [31:0] outReadData,
  output logic [31:0] outAlu_Result,
  output logic [4:0]  outmuxRegFileD,
  output logic        outregWrite,
  output logic        outmemtoReg,
  output logic        o_dbg_state
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        outMisalign
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0]  w_addr;
  logic               w_mem_op;
  logic               w_misalign;
  logic               w_stall;
  logic               w_complete;
  logic               w_we;
  logic               w_unused;

  logic               r_valid;
  logic [31:0]        r_read_data;
  logic [31:0]        r_alu;
  logic [4:0]         r_dst;
  logic               r_reg_write;
  logic               r_mem_to_reg;
  logic               r_misalign;

  assign w_addr   = Alu_result[ADDR_W+1:2];
  assign w_mem_op = inValid & (memtoRead | memtoWrite);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign  = w_mem_op & (Alu_result[1:0] != 2'b00);
  assign outMisalign = r_misalign;
  assign w_unused    = ^Alu_result[31:ADDR_W+2];
`else
  assign w_misalign  = 1'b0;
  assign w_unused    = ^{Alu_result[31:ADDR_W+2], Alu_result[1:0], r_misalign};
`endif

  // Handshake: while stall=1 upstream holds every EX/MEM input stable; the access
  // completes (MEM/WB slot loads) on the first rising edge seen with stall=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_next_state == S_WAIT)
        r_cnt <= CNT_INIT;
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_mem_op && WAIT_STATES > 0) w_next_state = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall    = 1'b0;
    w_complete = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_stall    = w_mem_op && (WAIT_STATES > 0);
        w_complete = inValid && !w_stall;
      end
      S_WAIT: begin
        w_stall    = (r_cnt != '0);
        w_complete = inValid && (r_cnt == '0);
      end
      default: begin
        w_stall    = 1'b0;
        w_complete = 1'b0;
      end
    endcase
  end

  assign stall        = w_stall;
  assign pcSrc        = branch & zeroflag & inValid & (r_state == S_IDLE);
  assign branchTarget = pcAdder;
  assign o_dbg_state  = r_state;
  assign w_we         = w_complete & memtoWrite & ~w_misalign;

  // Array is never reset; an edge that sees rst high must not commit a pending store.
  always_ff @(posedge clk) begin
    if (w_we && !rst)
      r_mem[w_addr] <= DataWrite;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_read_data  <= '0;
      r_alu        <= '0;
      r_dst        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_misalign   <= 1'b0;
    end else if (w_complete) begin
      r_valid      <= 1'b1;
      r_alu        <= Alu_result;
      r_dst        <= muxRegFileD;
      r_reg_write  <= regWrite & ~w_misalign;
      r_mem_to_reg <= memtoReg;
      r_misalign   <= w_misalign;
      if (w_misalign)
        r_read_data <= '0;
      else if (memtoRead)
        r_read_data <= r_mem[w_addr];
    end else begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_misalign  <= 1'b0;
    end
  end

  assign outValid       = r_valid;
  assign outReadData    = r_read_data;
  assign outAlu_Result  = r_alu;
  assign outmuxRegFileD = r_dst;
  assign outregWrite    = r_reg_write;
  assign outmemtoReg    = r_mem_to_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-abort sequence, and random
// traffic scored against a word-array model of the data memory.
module tb_mem_access_stage;

  localparam int ADDR_W = 8;
  localparam int WS     = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MAXW   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, zeroflag, branch, memtoWrite, memtoRead, regWrite, memtoReg;
  logic [31:0] pcAdder, Alu_result, DataWrite;
  logic [4:0]  muxRegFileD;
  logic        stall, pcSrc, outValid, outregWrite, outmemtoReg, o_dbg_state;
  logic [31:0] branchTarget, outReadData, outAlu_Result;
  logic [4:0]  outmuxRegFileD;
`ifdef MISALIGN_TRAP_EN
  logic        outMisalign;
`endif

  mem_access_stage #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .pcAdder(pcAdder), .zeroflag(zeroflag),
    .Alu_result(Alu_result), .DataWrite(DataWrite), .muxRegFileD(muxRegFileD),
    .branch(branch), .memtoWrite(memtoWrite), .memtoRead(memtoRead), .regWrite(regWrite),
    .memtoReg(memtoReg), .stall(stall), .pcSrc(pcSrc), .branchTarget(branchTarget),
    .outValid(outValid), .outReadData(outReadData), .outAlu_Result(outAlu_Result),
    .outmuxRegFileD(outmuxRegFileD), .outregWrite(outregWrite), .outmemtoReg(outmemtoReg),
    .o_dbg_state(o_dbg_state)
`ifdef MISALIGN_TRAP_EN
    , .outMisalign(outMisalign)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v, br, zf, mw, mr, rw, m2r;
    logic [31:0] pc, alu, wd;
    logic [4:0]  dst;
    logic        e_valid, e_rw, e_m2r, e_pcsrc, e_mis;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_dst;
    int          e_stall;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [71:0] exp_q[$];

  // reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rd, m_alu;
  logic [4:0]  m_dst;
  logic        m_m2r;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic v, br, zf, mw, mr, rw, m2r,
                               input logic [31:0] pc, alu, wd, input logic [4:0] dst,
                               input logic e_valid, input logic [31:0] e_rd, e_alu,
                               input logic [4:0] e_dst, input logic e_rw, e_m2r,
                               input int e_stall, input logic e_pcsrc);
    vec_t t;
    t.v = v; t.br = br; t.zf = zf; t.mw = mw; t.mr = mr; t.rw = rw; t.m2r = m2r;
    t.pc = pc; t.alu = alu; t.wd = wd; t.dst = dst;
    t.e_valid = e_valid; t.e_rd = e_rd; t.e_alu = e_alu; t.e_dst = e_dst;
    t.e_rw = e_rw; t.e_m2r = e_m2r; t.e_stall = e_stall; t.e_pcsrc = e_pcsrc; t.e_mis = 1'b0;
    return t;
  endfunction

  function automatic vec_t mk_in(input logic v, br, zf, mw, mr, rw, m2r,
                                 input logic [31:0] pc, alu, wd, input logic [4:0] dst);
    return mkv(v, br, zf, mw, mr, rw, m2r, pc, alu, wd, dst, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic m_reset();
    m_rd = '0; m_alu = '0; m_dst = '0; m_m2r = 1'b0;
  endtask

  // Behavioural model: memory is a plain word array indexed by byte address / 4 mod depth.
  function automatic vec_t model_step(input vec_t in);
    vec_t o;
    int   idx;
    logic memop;
    logic mis;
    o     = in;
    idx   = int'((in.alu >> 2) % DEPTH);
    memop = in.v && (in.mr || in.mw);
    mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis   = memop && ((in.alu % 4) != 0);
`endif
    if (in.v) begin
      if (mis) m_rd = '0;
      else if (in.mr) m_rd = m_mem[idx];
      if (in.mw && !mis) m_mem[idx] = in.wd;
      m_alu = in.alu; m_dst = in.dst; m_m2r = in.m2r;
    end
    o.e_valid = in.v;
    o.e_rw    = in.v && in.rw && !mis;
    o.e_rd    = m_rd;
    o.e_alu   = m_alu;
    o.e_dst   = m_dst;
    o.e_m2r   = m_m2r;
    o.e_stall = memop ? WS : 0;
    o.e_pcsrc = in.br && in.zf && in.v;
    o.e_mis   = mis;
    return o;
  endfunction

  // driver: called at posedge+1, returns at posedge+1 after the slot has loaded
  task automatic apply(input vec_t t, input string name);
    int stalls;
    logic [71:0] act;
    logic [71:0] exp;
    stalls = 0;
    inValid = t.v; branch = t.br; zeroflag = t.zf; memtoWrite = t.mw; memtoRead = t.mr;
    regWrite = t.rw; memtoReg = t.m2r; pcAdder = t.pc; Alu_result = t.alu;
    DataWrite = t.wd; muxRegFileD = t.dst;
    exp_q.push_back({t.e_valid, t.e_rd, t.e_alu, t.e_dst, t.e_rw, t.e_m2r});
    @(negedge clk);
    chk({name, ".pcSrc"}, 72'(pcSrc), 72'(t.e_pcsrc));
    chk({name, ".branchTarget"}, 72'(branchTarget), 72'(t.pc));
    while (stall === 1'b1 && stalls < MAXW) begin
      stalls++;
      @(negedge clk);
      chk({name, ".bubble"}, 72'(outValid), 72'(0));
    end
    chk({name, ".stall_cycles"}, 72'(stalls), 72'(t.e_stall));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    act = {outValid, outReadData, outAlu_Result, outmuxRegFileD, outregWrite, outmemtoReg};
    chk({name, ".slot"}, act, exp);
`ifdef MISALIGN_TRAP_EN
    chk({name, ".misalign"}, 72'(outMisalign), 72'(t.e_mis));
`endif
  endtask

  vec_t tbl [11];

  initial begin
    vec_t t;
    logic [31:0] a;
    // v br zf mw mr rw m2r  pc alu wd dst | e_valid e_rd e_alu e_dst e_rw e_m2r e_stall e_pcsrc
    tbl[0]  = mkv(1,0,0,1,0,0,0, 32'h0,  32'h20,  32'hDEADBEEF, 0,  1, 32'h0,        32'h20,  0,  0,0, 2, 0);
    tbl[1]  = mkv(1,0,0,0,1,1,1, 32'h0,  32'h20,  32'h0,        3,  1, 32'hDEADBEEF, 32'h20,  3,  1,1, 2, 0);
    tbl[2]  = mkv(1,0,0,0,0,1,0, 32'h0,  32'h1234,32'h0,        5,  1, 32'hDEADBEEF, 32'h1234,5,  1,0, 0, 0);
    tbl[3]  = mkv(1,1,1,0,0,0,0, 32'h40, 32'h0,   32'h0,        0,  1, 32'hDEADBEEF, 32'h0,   0,  0,0, 0, 1);
    tbl[4]  = mkv(1,1,0,0,0,0,0, 32'h80, 32'h8,   32'h0,        0,  1, 32'hDEADBEEF, 32'h8,   0,  0,0, 0, 0);
    tbl[5]  = mkv(0,1,1,0,1,1,1, 32'hC0, 32'h99,  32'h0,        12, 0, 32'hDEADBEEF, 32'h8,   0,  0,0, 0, 0);
    tbl[6]  = mkv(1,0,0,1,0,0,0, 32'h0,  32'h400, 32'h0BADCAFE, 0,  1, 32'hDEADBEEF, 32'h400, 0,  0,0, 2, 0);
    tbl[7]  = mkv(1,0,0,0,1,1,1, 32'h0,  32'h0,   32'h0,        7,  1, 32'h0BADCAFE, 32'h0,   7,  1,1, 2, 0);
    tbl[8]  = mkv(1,0,0,1,1,1,1, 32'h0,  32'h20,  32'h55AA55AA, 2,  1, 32'hDEADBEEF, 32'h20,  2,  1,1, 2, 0);
    tbl[9]  = mkv(1,0,0,0,1,1,1, 32'h0,  32'h20,  32'h0,        4,  1, 32'h55AA55AA, 32'h20,  4,  1,1, 2, 0);
    tbl[10] = mkv(1,0,0,0,0,0,0, 32'h0,  32'hFFFFFFFF, 32'h0,   31, 1, 32'h55AA55AA, 32'hFFFFFFFF, 31, 0,0, 0, 0);

    rst = 1'b1;
    inValid = 0; branch = 0; zeroflag = 0; memtoWrite = 0; memtoRead = 0; regWrite = 0;
    memtoReg = 0; pcAdder = '0; Alu_result = '0; DataWrite = '0; muxRegFileD = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.slot", {outValid, outReadData, outAlu_Result, outmuxRegFileD, outregWrite, outmemtoReg}, 72'h0);
    chk("reset.stall", 72'(stall), 72'(0));
    chk("reset.state", 72'(o_dbg_state), 72'(0));
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      t = model_step(tbl[i]);
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // store to byte address 0x22: aligned silently by default, trapped with the macro
    apply(model_step(mk_in(1,0,0,1,0,1,0, 0, 32'h22, 32'hCAFEF00D, 6)), "mis_store");
    apply(model_step(mk_in(1,0,0,0,1,1,1, 0, 32'h20, 32'h0, 6)), "mis_load");
`ifdef MISALIGN_TRAP_EN
    chk("mis_mem8", 72'(outReadData), 72'(32'h55AA55AA));
`else
    chk("mis_mem8", 72'(outReadData), 72'(32'hCAFEF00D));
`endif

    // reset mid-WAIT aborts the store to 0x10
    apply(model_step(mk_in(1,0,0,1,0,0,0, 0, 32'h10, 32'h11111111, 1)), "pre_store");
    inValid = 1; memtoWrite = 1; memtoRead = 0; regWrite = 0; branch = 0;
    Alu_result = 32'h10; DataWrite = 32'h22222222; muxRegFileD = 5'd1;
    @(negedge clk);
    chk("abort.stall", 72'(stall), 72'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.slot", {outValid, outReadData, outAlu_Result, outmuxRegFileD, outregWrite, outmemtoReg}, 72'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; inValid = 0; memtoWrite = 0;
    m_reset();
    apply(model_step(mk_in(1,0,0,0,1,1,1, 0, 32'h10, 32'h0, 9)), "abort_load");
    chk("abort.mem4", 72'(outReadData), 72'(32'h11111111));

    // fill every word (with random upper address bits) so later loads are defined
    for (int i = 0; i < DEPTH; i++) begin
      a = $urandom();
      a[9:2] = 8'(i);
      a[1:0] = 2'b00;
      apply(model_step(mk_in(1,0,0,1,0,0,0, $urandom(), a, $urandom(), 5'($urandom_range(0,31)))), "fill");
    end

    for (int i = 0; i < 300; i++) begin
      int kind;
      t = mk_in(0,0,0,0,0,0,0, $urandom(), $urandom(), $urandom(), 5'($urandom_range(0,31)));
      if ($urandom_range(0,3) != 0) t.alu[1:0] = 2'b00;
      t.rw  = 1'($urandom_range(0,1));
      t.m2r = 1'($urandom_range(0,1));
      t.zf  = 1'($urandom_range(0,1));
      kind = $urandom_range(0,4);
      case (kind)
        0: begin t.v = 1; t.mr = 1; end
        1: begin t.v = 1; t.mw = 1; end
        2: t.v = 1;
        3: begin t.v = 1; t.br = 1; end
        default: begin
          t.v  = 1'($urandom_range(0,1));
          t.mr = 1'($urandom_range(0,1));
          t.mw = 1'($urandom_range(0,1));
          t.br = 1'($urandom_range(0,1));
        end
      endcase
      apply(model_step(t), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
